// File: rtl/kpn_pkg.sv
// Shared definitions for the KPN processing network: default sample width and sample type.
package kpn_pkg;

    localparam int KPN_DATA_WIDTH = 16;

    typedef logic [KPN_DATA_WIDTH-1:0] kpn_sample_t;

endpackage

// File: rtl/delay_stage.sv
// One register of the delay chain: async active-high clear to 0.
// With DELAY_MODULE_STALL_EN defined, an enable input freezes the register when low.
module delay_stage
    import kpn_pkg::*;
#(
    parameter int DATA_WIDTH = KPN_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
`ifdef DELAY_MODULE_STALL_EN
    input  logic                  enable,
`endif
    input  logic [DATA_WIDTH-1:0] i_d,
    output logic [DATA_WIDTH-1:0] o_q
);

    logic [DATA_WIDTH-1:0] r_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q <= '0;
        end else begin
`ifdef DELAY_MODULE_STALL_EN
            if (enable) begin
                r_q <= i_d;
            end
`else
            r_q <= i_d;
`endif
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/delay_module.sv
// Fixed-latency z^-N delay element: entry_1 reappears on output_1 DELAY_NUMBER clocks later.
// Optional macro DELAY_MODULE_STALL_EN adds an enable port that freezes the whole chain.
module delay_module
    import kpn_pkg::*;
#(
    parameter int DATA_WIDTH   = KPN_DATA_WIDTH,
    parameter int DELAY_NUMBER = 1
) (
    input  logic                  clk,
    input  logic                  reset,
`ifdef DELAY_MODULE_STALL_EN
    input  logic                  enable,
`endif
    input  logic [DATA_WIDTH-1:0] entry_1,
    output logic [DATA_WIDTH-1:0] output_1
);

    generate
        if (DELAY_NUMBER == 0) begin : g_pass
            // No registers: clock, reset and enable have nothing to act on.
`ifdef DELAY_MODULE_STALL_EN
            logic [2:0] w_unused_ctrl;
            assign w_unused_ctrl = {clk, reset, enable};
`else
            logic [1:0] w_unused_ctrl;
            assign w_unused_ctrl = {clk, reset};
`endif
            assign output_1 = entry_1;
        end else begin : g_chain
            // w_stage[0] is the input tap; w_stage[i+1] is the output of register i.
            logic [DATA_WIDTH-1:0] w_stage [DELAY_NUMBER+1];

            assign w_stage[0] = entry_1;

            for (genvar i = 0; i < DELAY_NUMBER; i++) begin : g_stage
                delay_stage #(
                    .DATA_WIDTH(DATA_WIDTH)
                ) u_stage (
                    .clk    (clk),
                    .reset  (reset),
`ifdef DELAY_MODULE_STALL_EN
                    .enable (enable),
`endif
                    .i_d    (w_stage[i]),
                    .o_q    (w_stage[i+1])
                );
            end

            assign output_1 = w_stage[DELAY_NUMBER];
        end
    endgenerate

endmodule

// File: tb/tb_delay_module.sv
// Self-checking bench for delay_module at DELAY_NUMBER 4, 1 and 0 sharing one input stream.
// Define DELAY_MODULE_STALL_EN to build and exercise the enable variant.
module tb_delay_module;
    import kpn_pkg::*;

`ifdef DELAY_MODULE_STALL_EN
    localparam bit STALL = 1'b1;
    logic enable = 1'b1;
`else
    localparam bit STALL = 1'b0;
`endif

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    kpn_sample_t entry = '0;
    kpn_sample_t o4, o1, o0;

    int n_checks = 0;
    int n_fail   = 0;

    // Samples accepted since the last reset, oldest first.
    kpn_sample_t q[$];

    always #100 clk = ~clk;

    delay_module #(.DATA_WIDTH(16), .DELAY_NUMBER(4)) u_dut4 (
        .clk      (clk),
        .reset    (reset),
`ifdef DELAY_MODULE_STALL_EN
        .enable   (enable),
`endif
        .entry_1  (entry),
        .output_1 (o4)
    );

    delay_module #(.DATA_WIDTH(16), .DELAY_NUMBER(1)) u_dut1 (
        .clk      (clk),
        .reset    (reset),
`ifdef DELAY_MODULE_STALL_EN
        .enable   (enable),
`endif
        .entry_1  (entry),
        .output_1 (o1)
    );

    delay_module #(.DATA_WIDTH(16), .DELAY_NUMBER(0)) u_dut0 (
        .clk      (clk),
        .reset    (reset),
`ifdef DELAY_MODULE_STALL_EN
        .enable   (enable),
`endif
        .entry_1  (entry),
        .output_1 (o0)
    );

    // Output of an n-deep delay: the n-th most recent accepted sample, else 0.
    function automatic kpn_sample_t model_out(input int n);
        if (q.size() < n) return '0;
        return q[q.size() - n];
    endfunction

    // Present one sample for one clock, update the model at the edge, return at the next negedge.
    task automatic drive(input kpn_sample_t d, input logic en);
        entry = d;
`ifdef DELAY_MODULE_STALL_EN
        enable = en;
`endif
        @(posedge clk);
        if (!reset && (en || !STALL)) begin
            q.push_back(d);
            if (q.size() > 8) void'(q.pop_front());
        end
        @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        q.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        #10;
        reset = 1'b1;
        q.delete();
        #1;
        n_checks++;
        if (o4 !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_d4: got %h expected %h", o4, 16'h0000);
        end
        n_checks++;
        if (o1 !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_d1: got %h expected %h", o1, 16'h0000);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_const();
        kpn_sample_t exp4;
        for (int k = 1; k <= 8; k++) begin
            drive(16'd1500, 1'b1);
            exp4 = (k >= 4) ? 16'd1500 : 16'd0;
            n_checks++;
            if (o4 !== exp4) begin
                n_fail++;
                $display("FAIL const_d4 edge %0d: got %0d expected %0d", k, o4, exp4);
            end
            n_checks++;
            if (o1 !== 16'd1500) begin
                n_fail++;
                $display("FAIL const_d1 edge %0d: got %0d expected %0d", k, o1, 1500);
            end
        end
    endtask

    task automatic test_ramp();
        kpn_sample_t exp4;
        for (int i = 1; i <= 20; i++) begin
            drive(kpn_sample_t'(i), 1'b1);
            exp4 = (i >= 4) ? kpn_sample_t'(i - 3) : 16'd1500;
            n_checks++;
            if (o4 !== exp4) begin
                n_fail++;
                $display("FAIL ramp_d4 step %0d: got %0d expected %0d", i, o4, exp4);
            end
            n_checks++;
            if (o1 !== kpn_sample_t'(i)) begin
                n_fail++;
                $display("FAIL ramp_d1 step %0d: got %0d expected %0d", i, o1, i);
            end
        end
    endtask

    task automatic test_reset_midstream();
        kpn_sample_t exp4;
        for (int i = 0; i < 6; i++) drive(16'd1500, 1'b1);
        #50;
        reset = 1'b1;
        q.delete();
        #1;
        n_checks++;
        if (o4 !== 16'h0000) begin
            n_fail++;
            $display("FAIL midreset_d4: got %h expected %h", o4, 16'h0000);
        end
        n_checks++;
        if (o1 !== 16'h0000) begin
            n_fail++;
            $display("FAIL midreset_d1: got %h expected %h", o1, 16'h0000);
        end
        n_checks++;
        if (o0 !== 16'd1500) begin
            n_fail++;
            $display("FAIL midreset_d0: got %0d expected %0d", o0, 1500);
        end
        drive(16'd1500, 1'b1);
        drive(16'd1500, 1'b1);
        reset = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            drive(16'd1500, 1'b1);
            exp4 = (k >= 4) ? 16'd1500 : 16'd0;
            n_checks++;
            if (o4 !== exp4) begin
                n_fail++;
                $display("FAIL postreset_d4 edge %0d: got %0d expected %0d", k, o4, exp4);
            end
        end
    endtask

    task automatic test_passthrough();
        kpn_sample_t vals[8];
        vals[0] = 16'hFFFF;
        vals[1] = 16'h0000;
        for (int i = 2; i < 8; i++) vals[i] = kpn_sample_t'($urandom);
        for (int i = 0; i < 8; i++) begin
            entry = vals[i];
            #1;
            n_checks++;
            if (o0 !== vals[i]) begin
                n_fail++;
                $display("FAIL pass_d0 %0d: got %h expected %h", i, o0, vals[i]);
            end
            drive(vals[i], 1'b1);
            n_checks++;
            if (o1 !== vals[i]) begin
                n_fail++;
                $display("FAIL pass_d1 %0d: got %h expected %h", i, o1, vals[i]);
            end
        end
    endtask

    task automatic test_random();
        kpn_sample_t d;
        for (int i = 0; i < 40; i++) begin
            d = kpn_sample_t'($urandom);
            drive(d, 1'b1);
            n_checks++;
            if (o4 !== model_out(4)) begin
                n_fail++;
                $display("FAIL rand_d4 %0d: got %h expected %h", i, o4, model_out(4));
            end
            n_checks++;
            if (o1 !== model_out(1)) begin
                n_fail++;
                $display("FAIL rand_d1 %0d: got %h expected %h", i, o1, model_out(1));
            end
            n_checks++;
            if (o0 !== d) begin
                n_fail++;
                $display("FAIL rand_d0 %0d: got %h expected %h", i, o0, d);
            end
        end
    endtask

    task automatic test_pattern();
        kpn_sample_t exp4;
        for (int e = 1; e <= 12; e++) begin
            drive(((e - 1) % 2 == 0) ? 16'hAAAA : 16'h5555, 1'b1);
            exp4 = (e >= 4) ? (((e - 4) % 2 == 0) ? 16'hAAAA : 16'h5555) : model_out(4);
            n_checks++;
            if (o4 !== exp4) begin
                n_fail++;
                $display("FAIL pattern_d4 edge %0d: got %h expected %h", e, o4, exp4);
            end
        end
    endtask

`ifdef DELAY_MODULE_STALL_EN
    task automatic test_stall();
        kpn_sample_t din  [12] = '{16'd10, 16'd20, 16'd30, 16'd99, 16'd99, 16'd40,
                                  16'd50, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
        logic        en   [12] = '{1, 1, 1, 0, 0, 1, 1, 1, 1, 1, 1, 1};
        kpn_sample_t exp4 [12] = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd10,
                                  16'd20, 16'd30, 16'd40, 16'd50, 16'd0, 16'd0};
        kpn_sample_t exp1 [12] = '{16'd10, 16'd20, 16'd30, 16'd30, 16'd30, 16'd40,
                                  16'd50, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
        apply_reset();
        for (int e = 0; e < 12; e++) begin
            drive(din[e], en[e]);
            n_checks++;
            if (o4 !== exp4[e]) begin
                n_fail++;
                $display("FAIL stall_d4 edge %0d: got %0d expected %0d", e + 1, o4, exp4[e]);
            end
            n_checks++;
            if (o1 !== exp1[e]) begin
                n_fail++;
                $display("FAIL stall_d1 edge %0d: got %0d expected %0d", e + 1, o1, exp1[e]);
            end
            n_checks++;
            if (o4 !== model_out(4)) begin
                n_fail++;
                $display("FAIL stall_model_d4 edge %0d: got %0d expected %0d", e + 1, o4, model_out(4));
            end
        end
        enable = 1'b1;
    endtask
`endif

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_const();
        test_ramp();
        test_reset_midstream();
        test_passthrough();
        test_random();
        test_pattern();
`ifdef DELAY_MODULE_STALL_EN
        test_stall();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
